// File: rtl/agc_sq_rupt_seq.sv
// agc_sq_rupt_seq: sequence register (SQ + EXTEND qualifier) and interrupt
// request latch / priority encoder for the AGC control section.
//
// At every new-instruction strobe (NISQ) the block either loads the next
// order code from the write bus or, if an interrupt may be taken, forces the
// RUPT order code and records the vector address of the winning channel.
//
// Ports:
//   CLOCK     in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   GOJAM     in   synchronous restart (same values as rst, next edge)
//   WL        in   order-code bits loaded into SQ on NISQ
//   NISQ      in   new-instruction strobe
//   EXTPLS    in   EXTEND executed
//   INHPLS    in   INHINT executed
//   RELPLS    in   RELINT executed
//   RESUME    in   RESUME executed, ends interrupt-in-progress
//   OVNHRP    in   overflow in A, inhibits interrupt grant
//   MNHRPT    in   monitor interrupt inhibit
//   RUPT_REQ  in   per-channel request pulses (channel 0 highest priority)
//   SQ        out  current order code
//   SQEXT     out  current instruction is extended
//   FUTEXT    out  next instruction will be extended
//   INHINT    out  interrupts inhibited by program
//   IIP       out  interrupt in progress
//   RPTFRC    out  one-cycle pulse, RUPT forced on this NISQ
//   RUPT_VEC  out  vector of the last granted interrupt
//   PENDING   out  latched, not-yet-granted requests
module agc_sq_rupt_seq #(
   parameter int unsigned          NCHAN      = 10,
   parameter int unsigned          OPW        = 6,
   parameter logic [OPW-1:0]       RUPT_OP    = 6'o03,
   parameter int unsigned          VECW       = 12,
   parameter logic [VECW-1:0]      VEC_BASE   = 12'o4004,
   parameter int unsigned          VEC_STRIDE = 4
) (
   input  logic                CLOCK,
   input  logic                rst,
   input  logic                GOJAM,
   input  logic [OPW-1:0]      WL,
   input  logic                NISQ,
   input  logic                EXTPLS,
   input  logic                INHPLS,
   input  logic                RELPLS,
   input  logic                RESUME,
   input  logic                OVNHRP,
   input  logic                MNHRPT,
   input  logic [NCHAN-1:0]    RUPT_REQ,
   output logic [OPW-1:0]      SQ,
   output logic                SQEXT,
   output logic                FUTEXT,
   output logic                INHINT,
   output logic                IIP,
   output logic                RPTFRC,
   output logic [VECW-1:0]     RUPT_VEC,
   output logic [NCHAN-1:0]    PENDING
);

   // Channel index width; covers the full 1..16 channel range.
   localparam int unsigned WIDX = 5;

   logic [OPW-1:0]   sq_q,       sq_d;
   logic             sqext_q,    sqext_d;
   logic             futext_q,   futext_d;
   logic             inhint_q,   inhint_d;
   logic             iip_q,      iip_d;
   logic             rptfrc_q,   rptfrc_d;
   logic [VECW-1:0]  rupt_vec_q, rupt_vec_d;
   logic [NCHAN-1:0] pending_q,  pending_d;

   logic [WIDX-1:0]  winner;
   logic             grant;
   logic [NCHAN-1:0] grant_mask;
   logic [VECW-1:0]  win_vec;

   // Priority encoder: scan from the top so the lowest set index wins.
   always_comb begin
      winner = '0;
      for (int i = NCHAN - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            winner = WIDX'(i);
         end
      end
   end

   // Grant qualification; never between EXTEND and its extended instruction.
   always_comb begin
      grant      = NISQ & (|pending_q) & ~inhint_q & ~iip_q & ~OVNHRP &
                   ~MNHRPT & ~futext_q & ~EXTPLS;
      grant_mask = grant ? (NCHAN'(1) << winner) : '0;
      // Modulo-2^VECW arithmetic: the sum wraps by truncation.
      win_vec    = VEC_BASE + VECW'(winner) * VECW'(VEC_STRIDE);
   end

   // Next-state logic.
   always_comb begin
      sq_d       = sq_q;
      sqext_d    = sqext_q;
      futext_d   = futext_q;
      inhint_d   = inhint_q;
      iip_d      = iip_q;
      rptfrc_d   = 1'b0;
      rupt_vec_d = rupt_vec_q;
      // New requests are OR-ed in after the clear, so set wins over clear.
      pending_d  = (pending_q & ~grant_mask) | RUPT_REQ;

      if (NISQ) begin
         if (grant) begin
            sq_d       = RUPT_OP;
            sqext_d    = 1'b0;
            rptfrc_d   = 1'b1;
            rupt_vec_d = win_vec;
         end else begin
            sq_d     = WL;
            sqext_d  = futext_q | EXTPLS;
            futext_d = 1'b0;
         end
      end else if (EXTPLS) begin
         futext_d = 1'b1;
      end

      if (INHPLS) begin
         inhint_d = 1'b1;
      end else if (RELPLS) begin
         inhint_d = 1'b0;
      end

      if (grant) begin
         iip_d = 1'b1;
      end else if (RESUME) begin
         iip_d = 1'b0;
      end

      // Synchronous restart overrides every other input sampled this cycle.
      if (GOJAM) begin
         sq_d       = '0;
         sqext_d    = 1'b0;
         futext_d   = 1'b0;
         inhint_d   = 1'b1;
         iip_d      = 1'b0;
         rptfrc_d   = 1'b0;
         rupt_vec_d = VEC_BASE;
         pending_d  = '0;
      end
   end

   // State registers.
   always_ff @(posedge CLOCK or posedge rst) begin
      if (rst) begin
         sq_q       <= '0;
         sqext_q    <= 1'b0;
         futext_q   <= 1'b0;
         inhint_q   <= 1'b1;
         iip_q      <= 1'b0;
         rptfrc_q   <= 1'b0;
         rupt_vec_q <= VEC_BASE;
         pending_q  <= '0;
      end else begin
         sq_q       <= sq_d;
         sqext_q    <= sqext_d;
         futext_q   <= futext_d;
         inhint_q   <= inhint_d;
         iip_q      <= iip_d;
         rptfrc_q   <= rptfrc_d;
         rupt_vec_q <= rupt_vec_d;
         pending_q  <= pending_d;
      end
   end

   assign SQ       = sq_q;
   assign SQEXT    = sqext_q;
   assign FUTEXT   = futext_q;
   assign INHINT   = inhint_q;
   assign IIP      = iip_q;
   assign RPTFRC   = rptfrc_q;
   assign RUPT_VEC = rupt_vec_q;
   assign PENDING  = pending_q;

endmodule

// File: tb/tb_agc_sq_rupt_seq.sv
// Directed bench for agc_sq_rupt_seq: a 10-channel instance (default
// parameters) and a 16-channel instance share all control inputs.
module tb_agc_sq_rupt_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        gojam, nisq, extpls, inhpls, relpls, resume, ovnhrp, mnhrpt;
   logic [5:0]  wl;
   logic [9:0]  req_a;
   logic [15:0] req_b;

   logic [5:0]  sq_a, sq_b;
   logic        sqext_a, futext_a, inhint_a, iip_a, rptfrc_a;
   logic        sqext_b, futext_b, inhint_b, iip_b, rptfrc_b;
   logic [11:0] vec_a, vec_b;
   logic [9:0]  pend_a;
   logic [15:0] pend_b;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   agc_sq_rupt_seq u_dut_a (
      .CLOCK(clk), .rst(rst), .GOJAM(gojam), .WL(wl), .NISQ(nisq),
      .EXTPLS(extpls), .INHPLS(inhpls), .RELPLS(relpls), .RESUME(resume),
      .OVNHRP(ovnhrp), .MNHRPT(mnhrpt), .RUPT_REQ(req_a),
      .SQ(sq_a), .SQEXT(sqext_a), .FUTEXT(futext_a), .INHINT(inhint_a),
      .IIP(iip_a), .RPTFRC(rptfrc_a), .RUPT_VEC(vec_a), .PENDING(pend_a)
   );

   agc_sq_rupt_seq #(.NCHAN(16)) u_dut_b (
      .CLOCK(clk), .rst(rst), .GOJAM(gojam), .WL(wl), .NISQ(nisq),
      .EXTPLS(extpls), .INHPLS(inhpls), .RELPLS(relpls), .RESUME(resume),
      .OVNHRP(ovnhrp), .MNHRPT(mnhrpt), .RUPT_REQ(req_b),
      .SQ(sq_b), .SQEXT(sqext_b), .FUTEXT(futext_b), .INHINT(inhint_b),
      .IIP(iip_b), .RPTFRC(rptfrc_b), .RUPT_VEC(vec_b), .PENDING(pend_b)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      gojam = 0; nisq = 0; extpls = 0; inhpls = 0; relpls = 0;
      resume = 0; ovnhrp = 0; mnhrpt = 0; req_a = '0; req_b = '0;
   endtask

   // Apply the current inputs across one rising edge, then drop all pulses.
   task automatic tick();
      @(posedge clk);
      #1;
      clr();
   endtask

   initial begin
      rst = 1'b1;
      wl  = '0;
      clr();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_sq",     32'(sq_a), 32'h0);
      chk("rst_inhint", 32'(inhint_a), 32'h1);
      chk("rst_vec",    32'(vec_a), 32'(12'o4004));
      chk("rst_pend",   32'(pend_a), 32'h0);
      rst = 1'b0;

      // Plain load
      relpls = 1; tick();
      chk("rel_inhint", 32'(inhint_a), 32'h0);
      nisq = 1; wl = 6'o25; tick();
      chk("load_sq",     32'(sq_a), 32'(6'o25));
      chk("load_sqext",  32'(sqext_a), 32'h0);
      chk("load_rptfrc", 32'(rptfrc_a), 32'h0);

      // Async reset mid-cycle with pending requests
      req_a = 10'b101; inhpls = 1; tick();
      chk("pre_rst_pend", 32'(pend_a), 32'b101);
      #2 rst = 1'b1;
      #1;
      chk("arst_sq",     32'(sq_a), 32'h0);
      chk("arst_inhint", 32'(inhint_a), 32'h1);
      chk("arst_iip",    32'(iip_a), 32'h0);
      chk("arst_pend",   32'(pend_a), 32'h0);
      chk("arst_vec",    32'(vec_a), 32'(12'o4004));
      rst = 1'b0;

      // EXTEND blocks the grant for the extended instruction
      relpls = 1; req_a = 10'b100; tick();
      chk("ext_pend", 32'(pend_a), 32'b100);
      extpls = 1; tick();
      chk("ext_futext", 32'(futext_a), 32'h1);
      nisq = 1; wl = 6'o11; tick();
      chk("ext_sq",     32'(sq_a), 32'(6'o11));
      chk("ext_sqext",  32'(sqext_a), 32'h1);
      chk("ext_futclr", 32'(futext_a), 32'h0);
      chk("ext_nogrnt", 32'(rptfrc_a), 32'h0);
      chk("ext_pkeep",  32'(pend_a), 32'b100);
      nisq = 1; wl = 6'o77; tick();
      chk("ext2_sq",    32'(sq_a), 32'(6'o03));
      chk("ext2_vec",   32'(vec_a), 32'(12'o4014));
      chk("ext2_sqext", 32'(sqext_a), 32'h0);
      chk("ext2_iip",   32'(iip_a), 32'h1);
      chk("ext2_rpt",   32'(rptfrc_a), 32'h1);
      tick();
      chk("ext2_rpt1w", 32'(rptfrc_a), 32'h0);

      // Priority between channels 3 and 1
      resume = 1; req_a = 10'b1010; tick();
      chk("pri_iip0", 32'(iip_a), 32'h0);
      nisq = 1; wl = 6'o05; tick();
      chk("pri_vec",  32'(vec_a), 32'(12'o4010));
      chk("pri_pend", 32'(pend_a), 32'b1000);
      chk("pri_iip",  32'(iip_a), 32'h1);
      chk("pri_rpt",  32'(rptfrc_a), 32'h1);
      nisq = 1; wl = 6'o42; tick();
      chk("pri2_sq",   32'(sq_a), 32'(6'o42));
      chk("pri2_rpt",  32'(rptfrc_a), 32'h0);
      chk("pri2_pend", 32'(pend_a), 32'b1000);

      // Coincidences
      inhpls = 1; relpls = 1; tick();
      chk("co_inhint", 32'(inhint_a), 32'h1);
      relpls = 1; tick();
      resume = 1; req_a = 10'b0010; tick();
      chk("co_iip0", 32'(iip_a), 32'h0);
      nisq = 1; resume = 1; req_a = 10'b0010; wl = 6'o01; tick();
      chk("co_iip",  32'(iip_a), 32'h1);
      chk("co_vec",  32'(vec_a), 32'(12'o4010));
      chk("co_pend", 32'(pend_a), 32'b1010);

      // Inhibits
      resume = 1; tick();
      nisq = 1; ovnhrp = 1; wl = 6'o17; tick();
      chk("ovf_sq",   32'(sq_a), 32'(6'o17));
      chk("ovf_pend", 32'(pend_a), 32'b1010);
      chk("ovf_iip",  32'(iip_a), 32'h0);
      nisq = 1; mnhrpt = 1; wl = 6'o21; tick();
      chk("mon_sq",   32'(sq_a), 32'(6'o21));
      chk("mon_pend", 32'(pend_a), 32'b1010);
      chk("mon_rpt",  32'(rptfrc_a), 32'h0);

      // GOJAM overrides coincident inputs
      gojam = 1; nisq = 1; relpls = 1; wl = 6'o33; req_a = 10'b1; tick();
      chk("gj_sq",     32'(sq_a), 32'h0);
      chk("gj_inhint", 32'(inhint_a), 32'h1);
      chk("gj_pend",   32'(pend_a), 32'h0);
      chk("gj_iip",    32'(iip_a), 32'h0);

      // 16-channel instance, channel 15
      relpls = 1; req_b = 16'h8000; tick();
      chk("b_pend", 32'(pend_b), 32'h8000);
      nisq = 1; ovnhrp = 1; wl = 6'o44; tick();
      chk("b_ovf_sq",   32'(sq_b), 32'(6'o44));
      chk("b_ovf_pend", 32'(pend_b), 32'h8000);
      nisq = 1; wl = 6'o45; tick();
      chk("b_sq",   32'(sq_b), 32'(6'o03));
      chk("b_vec",  32'(vec_b), 32'(12'o4100));
      chk("b_pend0", 32'(pend_b), 32'h0);
      chk("b_rpt",  32'(rptfrc_b), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
